// File: rtl/full_adder_checker.sv
// Built-in self-test engine for a 1-bit full adder: steps all eight {a,b,cin}
// vectors, compares sum/carry against a golden model, and reports the results.
module full_adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_sum,
  input  logic       dut_carry,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] index;
  logic [3:0] settle_cnt;
  logic [1:0] expected;
  logic       mismatch;
  logic       accept;

  always_comb begin
    expected = {1'b0, dut_a} + {1'b0, dut_b} + {1'b0, dut_cin};
    mismatch = ({dut_carry, dut_sum} != expected);
    accept   = start && ((state == S_IDLE) || (state == S_DONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_APPLY;
      S_APPLY:        state_next = (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
      S_WAIT:         if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
      S_CHECK:        state_next = (index == 3'd7) ? S_DONE : S_APPLY;
      default:        state_next = S_IDLE;
    endcase
  end

  // The adder drive is loaded on the edge that enters APPLY, so it is stable
  // for the whole APPLY/WAIT/CHECK window of that vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index                    <= '0;
      settle_cnt               <= '0;
      {dut_a, dut_b, dut_cin}  <= '0;
      err_count                <= '0;
      first_fail_vec           <= '0;
      first_fail_valid         <= 1'b0;
    end else if (accept) begin
      index                    <= '0;
      settle_cnt               <= '0;
      {dut_a, dut_b, dut_cin}  <= '0;
      err_count                <= '0;
      first_fail_vec           <= '0;
      first_fail_valid         <= 1'b0;
    end else begin
      case (state)
        S_APPLY: settle_cnt <= '0;
        S_WAIT:  settle_cnt <= settle_cnt + 4'd1;
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (!first_fail_valid) begin
              first_fail_vec   <= index;
              first_fail_valid <= 1'b1;
            end
          end
          if (index != 3'd7) begin
            index                   <= index + 3'd1;
            {dut_a, dut_b, dut_cin} <= index + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
    done = (state == S_DONE);
    pass = done && (err_count == 4'd0);
  end

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: two instances (settle 2 and settle 0) driving
// a behavioural adder with selectable faults, checked against a vector table.
module tb_full_adder_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  int   mode = 0;  // 0 good adder, 1 carry stuck at 0, 2 inverted sum
  bit   sel = 1'b0;

  logic a0, b0, cin0, s0, c0, busy0, done0, pass0, ffvalid0;
  logic a1, b1, cin1, s1, c1, busy1, done1, pass1, ffvalid1;
  logic [3:0] err0, err1;
  logic [2:0] ffv0, ffv1;

  logic o_a, o_b, o_cin, o_busy, o_done, o_pass, o_ffvalid;
  logic [3:0] o_err;
  logic [2:0] o_ffv;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  full_adder_checker #(.SETTLE_CYCLES(2)) u_chk2 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(s0), .dut_carry(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffvalid0)
  );

  full_adder_checker #(.SETTLE_CYCLES(0)) u_chk0 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(s1), .dut_carry(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  always_comb begin
    s0 = a0 ^ b0 ^ cin0;
    c0 = (a0 & b0) | (cin0 & (a0 ^ b0));
    s1 = a1 ^ b1 ^ cin1;
    c1 = (a1 & b1) | (cin1 & (a1 ^ b1));
    if (mode == 1) begin c0 = 1'b0; c1 = 1'b0; end
    if (mode == 2) begin s0 = ~s0; s1 = ~s1; end
  end

  always_comb begin
    if (sel) begin
      {o_a, o_b, o_cin} = {a1, b1, cin1};
      {o_busy, o_done, o_pass, o_ffvalid} = {busy1, done1, pass1, ffvalid1};
      o_err = err1; o_ffv = ffv1;
    end else begin
      {o_a, o_b, o_cin} = {a0, b0, cin0};
      {o_busy, o_done, o_pass, o_ffvalid} = {busy0, done0, pass0, ffvalid0};
      o_err = err0; o_ffv = ffv0;
    end
  end

  typedef struct {
    bit sel;
    int mode;
    int restart_at;
    int cycles;
    bit pass_e;
    int err;
    int ffv;
    bit ffvalid;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int per;
    int got;
    bit seq_ok;
    per    = v.sel ? 2 : 4;
    got    = -1;
    seq_ok = 1'b1;
    sel    = v.sel;
    mode   = v.mode;
    @(negedge clk);
    if (v.sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    check("accept_clears", int'({o_busy, o_done, o_ffvalid, o_err}), int'({1'b1, 1'b0, 1'b0, 4'd0}));
    for (int e = 0; e < 200; e++) begin
      if (o_done) begin got = e; break; end
      if (!o_busy || ({o_a, o_b, o_cin} != 3'(e / per))) seq_ok = 1'b0;
      if (e == v.restart_at) begin
        if (v.sel) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
    end
    check("vector_sequence", int'(seq_ok), 1);
    check("run_cycles", got, v.cycles);
    check("pass", int'(o_pass), int'(v.pass_e));
    check("err_count", int'(o_err), v.err);
    check("first_fail_vec", int'(o_ffv), v.ffv);
    check("first_fail_valid", int'(o_ffvalid), int'(v.ffvalid));
    check("idle_after_done", int'({o_busy, o_a, o_b, o_cin}), int'({1'b0, 3'd7}));
  endtask

  initial begin
    //        sel  mode restart cyc pass err ffv ffvalid
    tbl[0] = '{1'b0, 0, -1, 32, 1'b1, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1, -1, 32, 1'b0, 4, 3, 1'b1};
    tbl[2] = '{1'b0, 2, -1, 32, 1'b0, 8, 0, 1'b1};
    tbl[3] = '{1'b0, 0, 10, 32, 1'b1, 0, 0, 1'b0};
    tbl[4] = '{1'b0, 1, 10, 32, 1'b0, 4, 3, 1'b1};
    tbl[5] = '{1'b1, 0, -1, 16, 1'b1, 0, 0, 1'b0};
    tbl[6] = '{1'b1, 2, -1, 16, 1'b0, 8, 0, 1'b1};
    tbl[7] = '{1'b1, 0, -1, 16, 1'b1, 0, 0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs_chk2", int'({a0, b0, cin0, busy0, done0, pass0, ffvalid0, ffv0, err0}), 0);
    check("reset_outputs_chk0", int'({a1, b1, cin1, busy1, done1, pass1, ffvalid1, ffv1, err1}), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset during the WAIT of vector 4, after vector 3 has already failed.
    sel  = 1'b0;
    mode = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_abort_vec", int'({a0, b0, cin0}), 4);
    check("pre_abort_err", int'({ffvalid0, err0}), int'({1'b1, 4'd1}));
    #2 rst = 1'b1;
    #1 check("abort_outputs", int'({a0, b0, cin0, busy0, done0, pass0, ffvalid0, ffv0, err0}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0]);

    // Start coinciding with reset must not launch a run.
    @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start0 = 1'b0;
    @(negedge clk);
    check("start_during_reset", int'({busy0, done0}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/full_adder_checker.md
Name: full_adder_checker

Overview:
Self-checking stimulus/response engine for the 1-bit full adder. It drives all 8 input combinations (a, b, cin) into a full adder under test and samples sum/carry against a golden model. It counts mismatches, records the first failing vector, and reports pass/fail. It sits beside the adder instance as the consumer of its outputs, for bring-up and built-in self-test.

Parameters:
SETTLE_CYCLES, 2, clock cycles the vector is held after APPLY before sampling; legal range 0..15.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a run when not busy
dut_a  output  1  adder operand a
dut_b  output  1  adder operand b
dut_cin  output  1  adder carry-in
dut_sum  input  1  adder sum output under test
dut_carry  input  1  adder carry output under test
busy  output  1  high while a run is in progress
done  output  1  high from run completion until the next accepted start or reset
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  4  number of mismatching vectors in the current/last run (0..8)
first_fail_vec  output  3  index {a,b,cin} of the first mismatch; valid when first_fail_valid
first_fail_valid  output  1  set on the first mismatch of a run

Behaviour:
- Reset (async, rst=1): state=IDLE; vector index=0; settle counter=0. All outputs = 0, including dut_a/b/cin, busy, done, pass, err_count, first_fail_vec and first_fail_valid.
- Vector encoding: index i in 0..7 maps to dut_a=i[2], dut_b=i[1], dut_cin=i[0]. Vectors are applied in ascending order 0 to 7, each exactly once per run.
- Golden model: expected {carry,sum} = a + b + cin (2-bit result).
- States:
  - IDLE
  - APPLY: 1 cycle; the dut_* drive is updated to the current index.
  - WAIT: SETTLE_CYCLES cycles; skipped when SETTLE_CYCLES=0.
  - CHECK: 1 cycle; compares dut_sum/dut_carry against expected.
  - DONE
- Transitions:
  - IDLE or DONE + start=1 -> APPLY on the next edge with index 0. On that same edge: err_count=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0, busy=1.
  - APPLY -> WAIT, or -> CHECK if SETTLE_CYCLES=0.
  - WAIT -> CHECK after SETTLE_CYCLES cycles.
  - CHECK -> APPLY with index+1 if index<7; else -> DONE.
  - On entering DONE: busy=0, done=1, pass=(final err_count==0).
- dut_a/b/cin are registered and held constant from APPLY through CHECK. They keep the last vector (index 7) in DONE and return to 0 only on reset.
- CHECK compares the dut_* inputs directly in that cycle; the compare result is registered at the end of CHECK.
  - On mismatch: err_count increments by 1 (maximum 8, no overflow possible).
  - If first_fail_valid=0, first_fail_vec<=index and first_fail_valid<=1 on the same edge.
- Run length from the start-accepting edge to done=1: 8*(SETTLE_CYCLES+2) cycles.
- start while busy=1 is ignored; the run continues unchanged.
- start in DONE restarts a run, clearing all results as above.
- Reset mid-run aborts immediately; all outputs return to their reset values. No partial results are retained.
- A start pulse asserted in the same cycle as rst is discarded.

Test Plan:
- Correct behavioural adder, SETTLE_CYCLES=2, start pulse -> busy for 32 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0; dut inputs step 000..111.
- Adder with carry stuck at 0 -> done, pass=0, err_count=4 (vectors 3,5,6,7), first_fail_vec=3, first_fail_valid=1.
- Adder with inverted sum -> err_count=8, first_fail_vec=0, pass=0.
- start re-pulsed at cycle 10 of a run -> ignored; done still arrives at cycle 32; results equal the single-run results.
- rst asserted during the WAIT of vector 4 -> all outputs 0 immediately. A following start gives a full clean 32-cycle run with correct results.
- SETTLE_CYCLES=0, correct adder -> done after 16 cycles, pass=1. Second start from DONE clears done/err_count on the accepting edge and repeats the run.
